// File: rtl/cgra_axil_csr_mq.sv
// AXI4-Lite CSR block for the CGRA: control/bitstream registers, per-channel
// descriptor/doorbell pairs and a sticky, maskable W1C interrupt status.
module cgra_axil_csr_mq #(
   parameter int ADDR_WIDTH = 32,
   parameter int NUM_CH     = 4
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [ADDR_WIDTH-1:0]  s_axi_awaddr_i,
   input  logic                   s_axi_awvalid_i,
   output logic                   s_axi_awready_o,
   input  logic [31:0]            s_axi_wdata_i,
   input  logic [3:0]             s_axi_wstrb_i,
   input  logic                   s_axi_wvalid_i,
   output logic                   s_axi_wready_o,
   output logic [1:0]             s_axi_bresp_o,
   output logic                   s_axi_bvalid_o,
   input  logic                   s_axi_bready_i,
   input  logic [ADDR_WIDTH-1:0]  s_axi_araddr_i,
   input  logic                   s_axi_arvalid_i,
   output logic                   s_axi_arready_o,
   output logic [31:0]            s_axi_rdata_o,
   output logic [1:0]             s_axi_rresp_o,
   output logic                   s_axi_rvalid_o,
   input  logic                   s_axi_rready_i,
   output logic                   cgra_start_o,
   output logic                   cfg_start_o,
   output logic                   cgra_reset_o,
   output logic [31:0]            bitstream_addr_o,
   output logic [15:0]            bitstream_size_o,
   output logic [NUM_CH*32-1:0]   ch_desc_addr_o,
   output logic [NUM_CH-1:0]      ch_doorbell_o,
   input  logic [NUM_CH-1:0]      ch_done_i,
   input  logic [NUM_CH-1:0]      ch_error_i,
   input  logic                   cgra_busy_i,
   input  logic                   cfg_done_i,
   output logic                   irq_o
);
   localparam int IW = 2 * NUM_CH;
   localparam logic [1:0] RESP_OKAY = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   logic              alive_q, alive_d;
   logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
   logic [5:0]        awaddr_q, awaddr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [3:0]        wstrb_q, wstrb_d;
   logic              bvalid_q, bvalid_d, rvalid_q, rvalid_d;
   logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              ctrl_reset_q, ctrl_reset_d;
   logic              cgra_start_q, cgra_start_d, cfg_start_q, cfg_start_d;
   logic [31:0]       bitstr_addr_q, bitstr_addr_d;
   logic [15:0]       bitstr_size_q, bitstr_size_d;
   logic [IW-1:0]     irq_mask_q, irq_mask_d, irq_status_q, irq_status_d;
   logic [31:0]       desc_q [NUM_CH];
   logic [31:0]       desc_d [NUM_CH];
   logic [NUM_CH-1:0] doorbell_q, doorbell_d;
   logic [NUM_CH-1:0] done_prev_q, err_prev_q;
   logic              irq_q, irq_d;

   logic        aw_hs, w_hs, ar_hs, commit, wr_hit, rd_hit;
   logic [5:0]  wr_word, rd_word;
   logic [31:0] wr_data, wr_mask, rd_data;
   logic [3:0]  wr_strb;
   logic [IW-1:0] irq_set, irq_clr;
   logic        unused_addr_bits;

   assign unused_addr_bits = ^{s_axi_awaddr_i[ADDR_WIDTH-1:8], s_axi_awaddr_i[1:0],
                               s_axi_araddr_i[ADDR_WIDTH-1:8], s_axi_araddr_i[1:0]};

   function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [31:0] mask);
      return (old_v & ~mask) | (new_v & mask);
   endfunction

   assign s_axi_awready_o = alive_q & ~aw_held_q & ~bvalid_q;
   assign s_axi_wready_o  = alive_q & ~w_held_q & ~bvalid_q;
   assign s_axi_arready_o = alive_q & ~rvalid_q;

   always_comb begin
      aw_hs   = s_axi_awvalid_i & s_axi_awready_o;
      w_hs    = s_axi_wvalid_i & s_axi_wready_o;
      ar_hs   = s_axi_arvalid_i & s_axi_arready_o;
      commit  = (aw_held_q | aw_hs) & (w_held_q | w_hs);
      // A held beat wins over the live bus, which is idle for that channel anyway.
      wr_word = aw_held_q ? awaddr_q : s_axi_awaddr_i[7:2];
      wr_data = w_held_q ? wdata_q : s_axi_wdata_i;
      wr_strb = w_held_q ? wstrb_q : s_axi_wstrb_i;
      wr_mask = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};
      rd_word = s_axi_araddr_i[7:2];

      alive_d       = 1'b1;
      aw_held_d     = aw_held_q;
      w_held_d      = w_held_q;
      awaddr_d      = awaddr_q;
      wdata_d       = wdata_q;
      wstrb_d       = wstrb_q;
      bvalid_d      = bvalid_q;
      bresp_d       = bresp_q;
      rvalid_d      = rvalid_q;
      rresp_d       = rresp_q;
      rdata_d       = rdata_q;
      ctrl_reset_d  = ctrl_reset_q;
      cgra_start_d  = 1'b0;
      cfg_start_d   = 1'b0;
      bitstr_addr_d = bitstr_addr_q;
      bitstr_size_d = bitstr_size_q;
      irq_mask_d    = irq_mask_q;
      desc_d        = desc_q;
      doorbell_d    = '0;
      irq_clr       = '0;
      wr_hit        = 1'b1;
      rd_hit        = 1'b1;
      rd_data       = '0;

      if (aw_hs) awaddr_d = s_axi_awaddr_i[7:2];
      if (w_hs) begin
         wdata_d = s_axi_wdata_i;
         wstrb_d = s_axi_wstrb_i;
      end

      case (wr_word)
         6'd0: if (commit && wr_strb[0]) begin
            ctrl_reset_d = wr_data[1];
            cgra_start_d = wr_data[0];
            cfg_start_d  = wr_data[2];
         end
         6'd2: if (commit) irq_clr = wr_data[IW-1:0] & wr_mask[IW-1:0];
         6'd3: if (commit) irq_mask_d = (irq_mask_q & ~wr_mask[IW-1:0])
                                      | (wr_data[IW-1:0] & wr_mask[IW-1:0]);
         6'd4: if (commit) bitstr_addr_d = merge_lanes(bitstr_addr_q, wr_data, wr_mask);
         6'd5: if (commit) bitstr_size_d = (bitstr_size_q & ~wr_mask[15:0])
                                         | (wr_data[15:0] & wr_mask[15:0]);
         default: wr_hit = 1'b0;
      endcase

      case (rd_word)
         6'd0: rd_data = {29'd0, 1'b0, ctrl_reset_q, 1'b0};
         6'd1: rd_data = {30'd0, cfg_done_i, cgra_busy_i};
         6'd2: rd_data[IW-1:0] = irq_status_q;
         6'd3: rd_data[IW-1:0] = irq_mask_q;
         6'd4: rd_data = bitstr_addr_q;
         6'd5: rd_data[15:0] = bitstr_size_q;
         default: rd_hit = 1'b0;
      endcase

      for (int i = 0; i < NUM_CH; i++) begin
         if (wr_word == 6'(8 + 2*i)) begin
            wr_hit = 1'b1;
            if (commit) desc_d[i] = merge_lanes(desc_q[i], wr_data, wr_mask);
         end
         if (wr_word == 6'(9 + 2*i)) begin
            wr_hit = 1'b1;
            if (commit) doorbell_d[i] = wr_strb[0];
         end
         if (rd_word == 6'(8 + 2*i)) begin
            rd_hit  = 1'b1;
            rd_data = desc_q[i];
         end
         if (rd_word == 6'(9 + 2*i)) rd_hit = 1'b1;
      end

      if (commit) begin
         aw_held_d = 1'b0;
         w_held_d  = 1'b0;
         bvalid_d  = 1'b1;
         bresp_d   = wr_hit ? RESP_OKAY : RESP_SLVERR;
      end else begin
         if (aw_hs) aw_held_d = 1'b1;
         if (w_hs) w_held_d = 1'b1;
         if (bvalid_q && s_axi_bready_i) bvalid_d = 1'b0;
      end

      if (ar_hs) begin
         rvalid_d = 1'b1;
         rdata_d  = rd_hit ? rd_data : 32'd0;
         rresp_d  = rd_hit ? RESP_OKAY : RESP_SLVERR;
      end else if (rvalid_q && s_axi_rready_i) begin
         rvalid_d = 1'b0;
      end

      // Set after clear so a new edge in the W1C cycle is never lost.
      irq_set      = {ch_error_i & ~err_prev_q, ch_done_i & ~done_prev_q};
      irq_status_d = (irq_status_q & ~irq_clr) | irq_set;
      irq_d        = |(irq_status_q & irq_mask_q);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         alive_q       <= 1'b0;
         aw_held_q     <= 1'b0;
         w_held_q      <= 1'b0;
         awaddr_q      <= '0;
         wdata_q       <= '0;
         wstrb_q       <= '0;
         bvalid_q      <= 1'b0;
         bresp_q       <= '0;
         rvalid_q      <= 1'b0;
         rresp_q       <= '0;
         rdata_q       <= '0;
         ctrl_reset_q  <= 1'b0;
         cgra_start_q  <= 1'b0;
         cfg_start_q   <= 1'b0;
         bitstr_addr_q <= '0;
         bitstr_size_q <= '0;
         irq_mask_q    <= '0;
         irq_status_q  <= '0;
         for (int i = 0; i < NUM_CH; i++) desc_q[i] <= '0;
         doorbell_q    <= '0;
         done_prev_q   <= '0;
         err_prev_q    <= '0;
         irq_q         <= 1'b0;
      end else begin
         alive_q       <= alive_d;
         aw_held_q     <= aw_held_d;
         w_held_q      <= w_held_d;
         awaddr_q      <= awaddr_d;
         wdata_q       <= wdata_d;
         wstrb_q       <= wstrb_d;
         bvalid_q      <= bvalid_d;
         bresp_q       <= bresp_d;
         rvalid_q      <= rvalid_d;
         rresp_q       <= rresp_d;
         rdata_q       <= rdata_d;
         ctrl_reset_q  <= ctrl_reset_d;
         cgra_start_q  <= cgra_start_d;
         cfg_start_q   <= cfg_start_d;
         bitstr_addr_q <= bitstr_addr_d;
         bitstr_size_q <= bitstr_size_d;
         irq_mask_q    <= irq_mask_d;
         irq_status_q  <= irq_status_d;
         desc_q        <= desc_d;
         doorbell_q    <= doorbell_d;
         done_prev_q   <= ch_done_i;
         err_prev_q    <= ch_error_i;
         irq_q         <= irq_d;
      end
   end

   assign s_axi_bvalid_o   = bvalid_q;
   assign s_axi_bresp_o    = bresp_q;
   assign s_axi_rvalid_o   = rvalid_q;
   assign s_axi_rresp_o    = rresp_q;
   assign s_axi_rdata_o    = rdata_q;
   assign cgra_start_o     = cgra_start_q;
   assign cfg_start_o      = cfg_start_q;
   assign cgra_reset_o     = ctrl_reset_q;
   assign bitstream_addr_o = bitstr_addr_q;
   assign bitstream_size_o = bitstr_size_q;
   assign ch_doorbell_o    = doorbell_q;
   assign irq_o            = irq_q;

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_desc_out
      assign ch_desc_addr_o[32*gi +: 32] = desc_q[gi];
   end
endmodule

// File: tb/tb_cgra_axil_csr_mq.sv
// Bench for cgra_axil_csr_mq: vector table, timing/IRQ/reset sequences and
// randomized traffic checked against a word-level register model.
module tb_cgra_axil_csr_mq;
   localparam int NCH = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n;
   logic [31:0]       s_axi_awaddr_i, s_axi_wdata_i, s_axi_araddr_i;
   logic              s_axi_awvalid_i, s_axi_wvalid_i, s_axi_bready_i;
   logic              s_axi_arvalid_i, s_axi_rready_i;
   logic [3:0]        s_axi_wstrb_i;
   logic              s_axi_awready_o, s_axi_wready_o, s_axi_bvalid_o;
   logic              s_axi_arready_o, s_axi_rvalid_o;
   logic [1:0]        s_axi_bresp_o, s_axi_rresp_o;
   logic [31:0]       s_axi_rdata_o;
   logic              cgra_start_o, cfg_start_o, cgra_reset_o, irq_o;
   logic [31:0]       bitstream_addr_o;
   logic [15:0]       bitstream_size_o;
   logic [NCH*32-1:0] ch_desc_addr_o;
   logic [NCH-1:0]    ch_doorbell_o, ch_done_i, ch_error_i;
   logic              cgra_busy_i, cfg_done_i;

   cgra_axil_csr_mq #(.ADDR_WIDTH(32), .NUM_CH(NCH)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axi_awaddr_i(s_axi_awaddr_i), .s_axi_awvalid_i(s_axi_awvalid_i),
      .s_axi_awready_o(s_axi_awready_o),
      .s_axi_wdata_i(s_axi_wdata_i), .s_axi_wstrb_i(s_axi_wstrb_i),
      .s_axi_wvalid_i(s_axi_wvalid_i), .s_axi_wready_o(s_axi_wready_o),
      .s_axi_bresp_o(s_axi_bresp_o), .s_axi_bvalid_o(s_axi_bvalid_o),
      .s_axi_bready_i(s_axi_bready_i),
      .s_axi_araddr_i(s_axi_araddr_i), .s_axi_arvalid_i(s_axi_arvalid_i),
      .s_axi_arready_o(s_axi_arready_o),
      .s_axi_rdata_o(s_axi_rdata_o), .s_axi_rresp_o(s_axi_rresp_o),
      .s_axi_rvalid_o(s_axi_rvalid_o), .s_axi_rready_i(s_axi_rready_i),
      .cgra_start_o(cgra_start_o), .cfg_start_o(cfg_start_o),
      .cgra_reset_o(cgra_reset_o), .bitstream_addr_o(bitstream_addr_o),
      .bitstream_size_o(bitstream_size_o), .ch_desc_addr_o(ch_desc_addr_o),
      .ch_doorbell_o(ch_doorbell_o), .ch_done_i(ch_done_i), .ch_error_i(ch_error_i),
      .cgra_busy_i(cgra_busy_i), .cfg_done_i(cfg_done_i), .irq_o(irq_o)
   );

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end else begin
         $display("ok   %s: 0x%08h", name, act);
      end
   endtask

   // Pulse monitors: count high cycles, so a stretched pulse shows up as extra counts.
   int db_hi [NCH] = '{default: 0};
   int start_hi = 0;
   int cfg_hi = 0;
   always @(negedge clk) begin
      for (int i = 0; i < NCH; i++) if (ch_doorbell_o[i]) db_hi[i]++;
      if (cgra_start_o) start_hi++;
      if (cfg_start_o) cfg_hi++;
   end

   // Word-level register model.
   logic        ctrl_rst_m;
   logic [31:0] baddr_m;
   logic [15:0] bsize_m;
   logic [7:0]  mask_m, status_m;
   logic [31:0] desc_m [NCH];

   function automatic void model_reset();
      ctrl_rst_m = 1'b0; baddr_m = '0; bsize_m = '0; mask_m = '0; status_m = '0;
      for (int i = 0; i < NCH; i++) desc_m[i] = '0;
   endfunction

   function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                         input logic [3:0] strb);
      logic [31:0] r;
      r = old_v;
      for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
      return r;
   endfunction

   function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data,
                                              input logic [3:0] strb);
      int w;
      logic [31:0] t;
      w = int'(addr[7:2]);
      if (w == 0) begin
         if (strb[0]) ctrl_rst_m = data[1];
         return 2'b00;
      end
      if (w == 2) begin
         t = lanes(32'd0, data, strb);
         status_m = status_m & ~t[7:0];
         return 2'b00;
      end
      if (w == 3) begin
         t = lanes({24'd0, mask_m}, data, strb);
         mask_m = t[7:0];
         return 2'b00;
      end
      if (w == 4) begin
         baddr_m = lanes(baddr_m, data, strb);
         return 2'b00;
      end
      if (w == 5) begin
         t = lanes({16'd0, bsize_m}, data, strb);
         bsize_m = t[15:0];
         return 2'b00;
      end
      if (w >= 8 && w < 8 + 2*NCH) begin
         if (w % 2 == 0) desc_m[(w-8)/2] = lanes(desc_m[(w-8)/2], data, strb);
         return 2'b00;
      end
      return 2'b10;
   endfunction

   function automatic logic [33:0] model_read(input logic [31:0] addr);
      int w;
      w = int'(addr[7:2]);
      case (w)
         0: return {2'b00, 29'd0, 1'b0, ctrl_rst_m, 1'b0};
         1: return {2'b00, 30'd0, cfg_done_i, cgra_busy_i};
         2: return {2'b00, 24'd0, status_m};
         3: return {2'b00, 24'd0, mask_m};
         4: return {2'b00, baddr_m};
         5: return {2'b00, 16'd0, bsize_m};
         default: begin
            if (w >= 8 && w < 8 + 2*NCH) return (w % 2 == 0) ? {2'b00, desc_m[(w-8)/2]} : 34'd0;
            return {2'b10, 32'd0};
         end
      endcase
   endfunction

   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input int aw_dly, input int w_dly,
                            output logic [1:0] resp);
      bit aw_done, w_done, aw_go, w_go, got;
      aw_done = 0; w_done = 0; got = 0;
      resp = 2'b11;
      @(negedge clk);
      s_axi_awaddr_i = addr; s_axi_wdata_i = data; s_axi_wstrb_i = strb;
      for (int k = 0; k < 64; k++) begin
         s_axi_awvalid_i = !aw_done && k >= aw_dly;
         s_axi_wvalid_i  = !w_done && k >= w_dly;
         aw_go = s_axi_awvalid_i && s_axi_awready_o;
         w_go  = s_axi_wvalid_i && s_axi_wready_o;
         @(negedge clk);
         if (aw_go) aw_done = 1;
         if (w_go) w_done = 1;
         if (aw_done && w_done) break;
      end
      s_axi_awvalid_i = 0; s_axi_wvalid_i = 0;
      if (!(aw_done && w_done)) begin
         checks++; errors++;
         $display("FAIL wr_handshake_timeout: addr 0x%08h not accepted, expected acceptance", addr);
         return;
      end
      s_axi_bready_i = 1;
      for (int k = 0; k < 64; k++) begin
         if (s_axi_bvalid_o) begin
            resp = s_axi_bresp_o; got = 1;
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
      s_axi_bready_i = 0;
      if (!got) begin
         checks++; errors++;
         $display("FAIL wr_bvalid_timeout: addr 0x%08h no response, expected bvalid", addr);
      end
   endtask

   task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                           output logic [1:0] resp);
      bit done, go, got;
      done = 0; got = 0;
      data = 32'hDEAD_BEEF; resp = 2'b11;
      @(negedge clk);
      s_axi_araddr_i = addr; s_axi_arvalid_i = 1;
      for (int k = 0; k < 64; k++) begin
         go = s_axi_arready_o;
         @(negedge clk);
         if (go) begin done = 1; break; end
      end
      s_axi_arvalid_i = 0;
      if (!done) begin
         checks++; errors++;
         $display("FAIL rd_ar_timeout: addr 0x%08h not accepted, expected acceptance", addr);
         return;
      end
      s_axi_rready_i = 1;
      for (int k = 0; k < 64; k++) begin
         if (s_axi_rvalid_o) begin
            data = s_axi_rdata_o; resp = s_axi_rresp_o; got = 1;
            @(negedge clk);
            break;
         end
         @(negedge clk);
      end
      s_axi_rready_i = 0;
      if (!got) begin
         checks++; errors++;
         $display("FAIL rd_rvalid_timeout: addr 0x%08h no data, expected rvalid", addr);
      end
   endtask

   typedef struct {
      bit          wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic [31:0] exp_data;
      logic [1:0]  exp_resp;
   } vec_t;
   vec_t vecs[$];

   task automatic add_vec(input bit wr, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [31:0] exp_data,
                          input logic [1:0] exp_resp);
      vec_t v;
      v.wr = wr; v.addr = addr; v.data = data; v.strb = strb;
      v.exp_data = exp_data; v.exp_resp = exp_resp;
      vecs.push_back(v);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1);
   end

   initial begin
      logic [31:0] rd;
      logic [1:0]  rsp, mrsp;
      logic [33:0] mexp;
      int s0, s1, w;
      logic [31:0] a, d;
      logic [3:0]  st;

      rst_n = 0;
      s_axi_awaddr_i = 0; s_axi_awvalid_i = 0; s_axi_wdata_i = 0; s_axi_wstrb_i = 0;
      s_axi_wvalid_i = 0; s_axi_bready_i = 0; s_axi_araddr_i = 0; s_axi_arvalid_i = 0;
      s_axi_rready_i = 0; ch_done_i = 0; ch_error_i = 0; cgra_busy_i = 0; cfg_done_i = 0;
      model_reset();
      repeat (3) @(negedge clk);
      check("rst_awready_low", 32'(s_axi_awready_o), 32'd0);
      check("rst_bvalid_low", 32'(s_axi_bvalid_o), 32'd0);
      rst_n = 1;
      repeat (2) @(negedge clk);
      check("post_rst_readies", {29'd0, s_axi_awready_o, s_axi_wready_o, s_axi_arready_o}, 32'd7);
      check("post_rst_irq", 32'(irq_o), 32'd0);

      // Vector table, applied in order on a fresh register file.
      add_vec(1, 32'h10, 32'hAABBCCDD, 4'b0010, 32'h0, 2'b00);
      add_vec(0, 32'h10, 32'h0, 4'h0, 32'h0000CC00, 2'b00);
      add_vec(0, 32'h7C, 32'h0, 4'h0, 32'h0, 2'b10);
      add_vec(1, 32'h04, 32'hFFFFFFFF, 4'hF, 32'h0, 2'b10);
      add_vec(0, 32'h04, 32'h0, 4'h0, 32'h0, 2'b00);
      add_vec(0, 32'h10, 32'h0, 4'h0, 32'h0000CC00, 2'b00);
      add_vec(1, 32'h14, 32'h12345678, 4'hF, 32'h0, 2'b00);
      add_vec(0, 32'h14, 32'h0, 4'h0, 32'h00005678, 2'b00);
      add_vec(1, 32'h0C, 32'hFFFFFFFF, 4'hF, 32'h0, 2'b00);
      add_vec(0, 32'h0C, 32'h0, 4'h0, 32'h000000FF, 2'b00);
      add_vec(1, 32'h0C, 32'h0, 4'hF, 32'h0, 2'b00);
      add_vec(0, 32'h0C, 32'h0, 4'h0, 32'h0, 2'b00);
      add_vec(1, 32'h00, 32'h00000007, 4'h1, 32'h0, 2'b00);
      add_vec(0, 32'h00, 32'h0, 4'h0, 32'h00000002, 2'b00);
      add_vec(1, 32'h00, 32'h0, 4'h1, 32'h0, 2'b00);
      add_vec(0, 32'h00, 32'h0, 4'h0, 32'h0, 2'b00);
      add_vec(1, 32'h2C, 32'h0, 4'h1, 32'h0, 2'b00);
      add_vec(0, 32'h2C, 32'h0, 4'h0, 32'h0, 2'b00);
      add_vec(0, 32'h18, 32'h0, 4'h0, 32'h0, 2'b10);
      add_vec(0, 32'h40, 32'h0, 4'h0, 32'h0, 2'b10);
      add_vec(1, 32'h40, 32'h1, 4'hF, 32'h0, 2'b10);
      add_vec(1, 32'h1C, 32'h1, 4'hF, 32'h0, 2'b10);
      add_vec(1, 32'h38, 32'hCAFEF00D, 4'hF, 32'h0, 2'b00);
      add_vec(0, 32'h38, 32'h0, 4'h0, 32'hCAFEF00D, 2'b00);
      add_vec(1, 32'h38, 32'h12345678, 4'b1001, 32'h0, 2'b00);
      add_vec(0, 32'h3B, 32'h0, 4'h0, 32'h12FEF078, 2'b00);
      add_vec(0, 32'h138, 32'h0, 4'h0, 32'h12FEF078, 2'b00);

      foreach (vecs[i]) begin
         if (vecs[i].wr) begin
            axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, rsp);
            mrsp = model_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
            check($sformatf("vec%0d_wr_%02h_resp", i, vecs[i].addr[7:0]), 32'(rsp), 32'(vecs[i].exp_resp));
         end else begin
            axi_read(vecs[i].addr, rd, rsp);
            check($sformatf("vec%0d_rd_%02h_data", i, vecs[i].addr[7:0]), rd, vecs[i].exp_data);
            check($sformatf("vec%0d_rd_%02h_resp", i, vecs[i].addr[7:0]), 32'(rsp), 32'(vecs[i].exp_resp));
         end
      end
      check("out_bitstream_addr", bitstream_addr_o, 32'h0000CC00);
      check("out_bitstream_size", 32'(bitstream_size_o), 32'h5678);
      check("out_desc3", ch_desc_addr_o[3*32 +: 32], 32'h12FEF078);

      // AW three cycles ahead of W: AW is held, bvalid follows the W handshake.
      @(negedge clk);
      s_axi_awaddr_i = 32'h28; s_axi_awvalid_i = 1;
      s_axi_wdata_i = 32'h8000_1000; s_axi_wstrb_i = 4'hF;
      check("t1_awready_c0", 32'(s_axi_awready_o), 32'd1);
      @(negedge clk);
      s_axi_awvalid_i = 0;
      check("t1_awready_held", 32'(s_axi_awready_o), 32'd0);
      check("t1_bvalid_c1", 32'(s_axi_bvalid_o), 32'd0);
      @(negedge clk);
      check("t1_bvalid_c2", 32'(s_axi_bvalid_o), 32'd0);
      @(negedge clk);
      check("t1_bvalid_c3", 32'(s_axi_bvalid_o), 32'd0);
      check("t1_wready_c3", 32'(s_axi_wready_o), 32'd1);
      s_axi_wvalid_i = 1;
      @(negedge clk);
      s_axi_wvalid_i = 0;
      check("t1_bvalid_c4", 32'(s_axi_bvalid_o), 32'd1);
      check("t1_bresp", 32'(s_axi_bresp_o), 32'd0);
      s_axi_bready_i = 1;
      @(negedge clk);
      s_axi_bready_i = 0;
      check("t1_bvalid_cleared", 32'(s_axi_bvalid_o), 32'd0);
      mrsp = model_write(32'h28, 32'h8000_1000, 4'hF);
      axi_read(32'h28, rd, rsp);
      check("t1_read_desc1", rd, 32'h8000_1000);

      // Doorbell ch2 lives at 0x24 + 8*2.
      s0 = db_hi[2]; s1 = db_hi[0] + db_hi[1] + db_hi[3];
      axi_write(32'h34, 32'h0, 4'h1, 0, 0, rsp);
      repeat (2) @(negedge clk);
      check("db2_first_pulse", 32'(db_hi[2] - s0), 32'd1);
      axi_write(32'h34, 32'h0, 4'h1, 1, 0, rsp);
      repeat (2) @(negedge clk);
      check("db2_second_pulse", 32'(db_hi[2] - s0), 32'd2);
      axi_write(32'h34, 32'hFFFFFFFF, 4'b1110, 0, 0, rsp);
      repeat (2) @(negedge clk);
      check("db2_no_strb0", 32'(db_hi[2] - s0), 32'd2);
      check("db_other_quiet", 32'(db_hi[0] + db_hi[1] + db_hi[3] - s1), 32'd0);

      s0 = start_hi; s1 = cfg_hi;
      axi_write(32'h00, 32'h1, 4'h1, 0, 2, rsp);
      repeat (2) @(negedge clk);
      check("ctrl_start_pulse", 32'(start_hi - s0), 32'd1);
      check("ctrl_cfg_quiet", 32'(cfg_hi - s1), 32'd0);
      axi_write(32'h00, 32'h5, 4'b1110, 0, 0, rsp);
      repeat (2) @(negedge clk);
      check("ctrl_no_strb0", 32'(start_hi - s0), 32'd1);
      axi_write(32'h00, 32'h6, 4'h1, 0, 0, rsp);
      mrsp = model_write(32'h00, 32'h6, 4'h1);
      repeat (2) @(negedge clk);
      check("ctrl_cfg_pulse", 32'(cfg_hi - s1), 32'd1);
      check("ctrl_reset_level", 32'(cgra_reset_o), 32'd1);
      axi_write(32'h00, 32'h0, 4'h1, 0, 0, rsp);
      mrsp = model_write(32'h00, 32'h0, 4'h1);
      check("ctrl_reset_clear", 32'(cgra_reset_o), 32'd0);

      cgra_busy_i = 1;
      axi_read(32'h04, rd, rsp);
      check("status_busy", rd, 32'h1);
      cfg_done_i = 1;
      axi_read(32'h04, rd, rsp);
      check("status_both", rd, 32'h3);
      cgra_busy_i = 0; cfg_done_i = 0;

      // Interrupts.
      axi_write(32'h0C, 32'h01, 4'hF, 0, 0, rsp);
      mrsp = model_write(32'h0C, 32'h01, 4'hF);
      @(negedge clk);
      ch_done_i[0] = 1;
      @(negedge clk);
      check("irq_latency_one", 32'(irq_o), 32'd0);
      @(negedge clk);
      check("irq_raised", 32'(irq_o), 32'd1);
      status_m = 8'h01;
      axi_read(32'h08, rd, rsp);
      check("irq_status_done0", rd, 32'h01);
      ch_done_i[0] = 0;
      axi_write(32'h08, 32'h01, 4'hF, 0, 0, rsp);
      mrsp = model_write(32'h08, 32'h01, 4'hF);
      @(negedge clk);
      check("irq_cleared", 32'(irq_o), 32'd0);
      axi_read(32'h08, rd, rsp);
      check("irq_status_w1c", rd, 32'h0);

      ch_error_i[1] = 1;
      repeat (3) @(negedge clk);
      status_m = 8'h20;
      check("irq_masked_err", 32'(irq_o), 32'd0);
      axi_write(32'h08, 32'h20, 4'b0010, 0, 0, rsp);
      mrsp = model_write(32'h08, 32'h20, 4'b0010);
      axi_read(32'h08, rd, rsp);
      check("w1c_wrong_lane", rd, 32'h20);
      axi_write(32'h08, 32'h20, 4'h1, 0, 0, rsp);
      mrsp = model_write(32'h08, 32'h20, 4'h1);
      axi_read(32'h08, rd, rsp);
      check("w1c_level_no_reset", rd, 32'h0);
      ch_error_i[1] = 0;

      // Rising edge in the same cycle as the W1C commit: the bit stays set.
      fork
         axi_write(32'h08, 32'h01, 4'hF, 0, 0, rsp);
         begin
            @(negedge clk);
            ch_done_i[0] = 1;
         end
      join
      status_m = 8'h01;
      axi_read(32'h08, rd, rsp);
      check("w1c_set_wins", rd, 32'h01);
      check("w1c_set_wins_irq", 32'(irq_o), 32'd1);
      ch_done_i[0] = 0;
      axi_write(32'h08, 32'hFF, 4'hF, 0, 0, rsp);
      mrsp = model_write(32'h08, 32'hFF, 4'hF);
      axi_write(32'h0C, 32'h0, 4'hF, 0, 0, rsp);
      mrsp = model_write(32'h0C, 32'h0, 4'hF);

      // Randomized traffic against the model.
      for (int n = 0; n < 150; n++) begin
         w = $urandom_range(0, 35);
         a = $urandom();
         a[7:2] = 6'(w);
         d = $urandom();
         st = 4'($urandom());
         if ($urandom_range(0, 1) == 1) begin
            axi_write(a, d, st, $urandom_range(0, 3), $urandom_range(0, 3), rsp);
            mrsp = model_write(a, d, st);
            check($sformatf("rnd%0d_wr_%02h_resp", n, a[7:0]), 32'(rsp), 32'(mrsp));
         end else begin
            axi_read(a, rd, rsp);
            mexp = model_read(a);
            check($sformatf("rnd%0d_rd_%02h_data", n, a[7:0]), rd, mexp[31:0]);
            check($sformatf("rnd%0d_rd_%02h_resp", n, a[7:0]), 32'(rsp), 32'(mexp[33:32]));
         end
      end
      check("rnd_out_baddr", bitstream_addr_o, baddr_m);
      check("rnd_out_bsize", 32'(bitstream_size_o), 32'(bsize_m));
      for (int i = 0; i < NCH; i++)
         check($sformatf("rnd_out_desc%0d", i), ch_desc_addr_o[32*i +: 32], desc_m[i]);

      // Reset with a response still pending.
      @(negedge clk);
      s_axi_awaddr_i = 32'h10; s_axi_wdata_i = 32'h11223344; s_axi_wstrb_i = 4'hF;
      s_axi_awvalid_i = 1; s_axi_wvalid_i = 1;
      @(negedge clk);
      s_axi_awvalid_i = 0; s_axi_wvalid_i = 0;
      check("rst_b_pending", 32'(s_axi_bvalid_o), 32'd1);
      rst_n = 0;
      @(negedge clk);
      check("rst_bvalid_dropped", 32'(s_axi_bvalid_o), 32'd0);
      check("rst_baddr_zero", bitstream_addr_o, 32'd0);
      check("rst_desc1_zero", ch_desc_addr_o[1*32 +: 32], 32'd0);
      rst_n = 1;
      model_reset();
      repeat (2) @(negedge clk);
      axi_write(32'h10, 32'h55AA55AA, 4'hF, 0, 0, rsp);
      mrsp = model_write(32'h10, 32'h55AA55AA, 4'hF);
      check("post_rst_wr_resp", 32'(rsp), 32'd0);
      axi_read(32'h10, rd, rsp);
      check("post_rst_rd_baddr", rd, 32'h55AA55AA);
      axi_read(32'h28, rd, rsp);
      check("post_rst_rd_desc1", rd, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
